inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time instruction memory writer for the fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive instruction-memory addresses from 0, then raises `fetch_en` so the PC register starts fetching only after the program is fully resident. It is the write side of the instruction memory that the fetch path reads.

## Interface
Parameters:
- `ADDR_W`, default 6, instruction-memory word-address width; matches the 6-bit PC. Depth is 2^ADDR_W words.

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  byte available on `in_data`.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `we`  output  1  instruction-memory write strobe, one cycle per word.
- `waddr`  output  ADDR_W  word address for `we`.
- `wdata`  output  32  instruction word for `we`.
- `fetch_en`  output  1  program loaded; drives the PC register enable / ROM `ce` gate.
- `words_loaded`  output  ADDR_W+1  count of words written.
- `err`  output  1  sticky load error.

## Operation
- A byte transfers on any cycle with `in_valid && in_ready`.
- Stream format: header byte N (word count, 0..255), then 4·N data bytes. The first byte of each word goes to `wdata[31:24]`; the fourth byte goes to `wdata[7:0]`.
- State HDR: `in_ready`=1.
  - On transfer, N is latched.
  - If N==0, go to DONE.
  - Otherwise go to DATA, with byte index and word index cleared.
- State DATA: `in_ready`=1.
  - Each transfer shifts the byte into the assembly register.
  - On the 4th byte of a word, the word is registered for writing and the word index increments.
  - After the 4th byte of word N-1, go to DONE.
- Writes:
  - `we` pulses the cycle after the 4th byte transfers, with `waddr` = word index and `wdata` = assembled word.
  - `words_loaded` increments with each `we`.
- Overflow: words with index ≥ 2^ADDR_W are consumed but not written. `we` stays low for them, `err` is set, and `words_loaded` saturates at 2^ADDR_W.
- State DONE:
  - `in_ready`=0.
  - `fetch_en`=1 from the cycle after the last `we` pulse. If N==0, it is 1 from the cycle after the header.
  - DONE is held until `rst`.
  - `fetch_en` stays 1 even if `err` is set, unless the checksum feature (see Configuration) forces it low.
- `in_valid` low stalls without state change. Gaps between bytes are unlimited.

## Timing
- Reset values: `in_ready`=0 during the `rst` cycle, then 1 (HDR). `we`=0, `waddr`=0, `wdata`=0, `fetch_en`=0, `words_loaded`=0, `err`=0.
- Latency from 4th-byte transfer to `we`: 1 cycle.
- Latency from last `we` to `fetch_en`: 1 cycle.
- Maximum throughput: 1 byte per cycle. Back-to-back words give `we` every 4th cycle.
- Reset mid-load returns to HDR next cycle.
  - A pending write scheduled for that cycle is dropped.
  - Memory words already written are not cleared.
  - `rst` takes priority over any simultaneous transfer.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - After the data bytes, state CHK (`in_ready`=1) accepts one trailer byte.
  - The trailer must equal the XOR of all 4·N data bytes. The header byte is excluded. For N==0 the expected value is 0x00.
  - On mismatch, `err` is set and `fetch_en` remains 0 permanently until reset.
  - On match, go to DONE with `fetch_en`=1 the following cycle.
  - Writes are not withheld pending the checksum.
- Not defined: no CHK state and no trailer byte. `err` reflects overflow only.

## Structure
- Shared package (`inst_loader_pkg`): state enum (HDR, DATA, CHK, DONE), `BYTES_PER_WORD`=4, `INST_W`=32.
- One natural sub-module: `byte_word_packer`. It holds the byte-to-word shift register and the byte index, and emits a one-cycle `word_valid` with the packed word. The FSM, addressing, counters and error logic stay in `inst_loader`.

## Test plan
- N=2, bytes 0x34 0x01 0x00 0x0A, then 0x3C 0x02 0xFF 0xFF → `we` at `waddr` 0 with `wdata` 0x3401000A, then at `waddr` 1 with 0x3C02FFFF. `fetch_en`=1 one cycle after the second `we`; `words_loaded`=2.
- Header 0x00 → no `we`; `fetch_en`=1 the cycle after the header (with checksum enabled, after trailer 0x00); `in_ready`=0 afterwards.
- N=1 with `in_valid` toggling 1,0,0,1,... across bytes 0xDE 0xAD 0xBE 0xEF → a single `we`, `wdata`=0xDEADBEEF, issued 1 cycle after the final byte transfers.
- ADDR_W=6, N=66 → 64 `we` pulses (`waddr` 0..63), `err`=1, `words_loaded`=64, `fetch_en`=1, and all 264 data bytes accepted.
- `rst` asserted after 6 data bytes of N=3, then a fresh stream with N=1 and bytes 0x11 0x22 0x33 0x44 → after `rst`, outputs are at reset values; a single `we` follows at `waddr` 0 with `wdata` 0x11223344.
- With `INST_LOADER_CHECKSUM_EN`: N=1, bytes 0x01 0x02 0x03 0x04, trailer 0x04 → `fetch_en`=1. With trailer 0x05 → `err`=1 and `fetch_en` stays 0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the loader state encoding and the word-assembly geometry.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_CHK,
        S_DONE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int INST_W         = 32;

endpackage

// File: rtl/inst_loader_byte_word_packer.sv
// Byte-to-word packer: shifts stream bytes MSB-first into a 32-bit word.
// Ports: clk, rst, clr_i (restart word), byte_valid_i/byte_i (accepted byte),
//        word_valid_o/word_o (combinational, high with the 4th byte of a word).
module byte_word_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [INST_W-1:0] word_o
);

    logic [1:0]        idx_q;
    logic [INST_W-9:0] sr_q;

    assign word_valid_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {sr_q, byte_i};

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            idx_q <= '0;
            sr_q  <= '0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            sr_q  <= {sr_q[INST_W-17:0], byte_i};
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction-memory writer: header N, then 4*N big-endian bytes.
// Ports: clk, rst (sync, active-high), in_valid/in_data/in_ready byte stream,
//        we/waddr/wdata memory write, fetch_en, words_loaded, err (sticky).
// Optional INST_LOADER_CHECKSUM_EN adds an XOR trailer byte after the data.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [INST_W-1:0] wdata,
    output logic              fetch_en,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q;
    logic [7:0]        n_q;
    logic [7:0]        widx_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [INST_W-1:0] wdata_q;
    logic              fetch_en_q;
    logic [ADDR_W:0]   wl_q;
    logic              err_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
    logic              chk_bad_q;
`endif

    logic              xfer;
    logic              hdr_xfer;
    logic              data_xfer;
    logic              word_valid;
    logic [INST_W-1:0] word;
    logic              last_word;
    logic              in_range;

    // rst gates the handshake so a byte offered during reset is never taken
    assign in_ready  = !rst && (state_q != S_DONE);
    assign xfer      = in_valid && in_ready;
    assign hdr_xfer  = xfer && (state_q == S_HDR);
    assign data_xfer = xfer && (state_q == S_DATA);
    assign last_word = (widx_q == n_q - 8'd1);
    assign in_range  = (32'(widx_q) < 32'(DEPTH));

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (hdr_xfer),
        .byte_valid_i (data_xfer),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR;
            n_q        <= '0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            fetch_en_q <= 1'b0;
            wl_q       <= '0;
            err_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_bad_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                S_HDR: begin
                    if (xfer) begin
                        n_q    <= in_data;
                        widx_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_q  <= '0;
                        state_q <= (in_data == 8'd0) ? S_CHK : S_DATA;
`else
                        if (in_data == 8'd0) begin
                            // empty program: enable fetch right away
                            state_q    <= S_DONE;
                            fetch_en_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
`endif
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ in_data;
`endif
                        if (word_valid) begin
                            widx_q <= widx_q + 8'd1;
                            if (in_range) begin
                                we_q    <= 1'b1;
                                waddr_q <= ADDR_W'(widx_q);
                                wdata_q <= word;
                                wl_q    <= wl_q + 1'b1;
                            end else begin
                                // word beyond memory: consumed, not written
                                err_q <= 1'b1;
                            end
                            if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
`endif
                            end
                        end
                    end
                end
                S_CHK: begin
`ifdef INST_LOADER_CHECKSUM_EN
                    if (xfer) begin
                        state_q <= S_DONE;
                        if (in_data == xor_q) begin
                            fetch_en_q <= 1'b1;
                        end else begin
                            err_q     <= 1'b1;
                            chk_bad_q <= 1'b1;
                        end
                    end
`endif
                end
                S_DONE: begin
                    // entered after the last write; enable one cycle after it
`ifdef INST_LOADER_CHECKSUM_EN
                    if (!chk_bad_q) fetch_en_q <= 1'b1;
`else
                    fetch_en_q <= 1'b1;
`endif
                end
            endcase
        end
    end

    // a write scheduled for a reset cycle is dropped
    assign we           = we_q && !rst;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign fetch_en     = fetch_en_q;
    assign words_loaded = wl_q;
    assign err          = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: random and directed byte streams.
// Expected writes come from a queue built from the stream as it is sent.
module tb_inst_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              fetch_en;
    logic [ADDR_W:0]   words_loaded;
    logic              err;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .fetch_en     (fetch_en),
        .words_loaded (words_loaded),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] data_q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("we_extra", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("waddr", 64'(waddr), 64'(mon_e.a));
                chk("wdata", 64'(wdata), 64'(mon_e.d));
                chk("we_cycle", 64'(cyc), 64'(mon_e.c));
            end
        end
    end

    function automatic int pick(input int g);
        return (g < 0) ? int'($urandom_range(0, 2)) : g;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap,
                             output int c);
        bit ok;
        int k;
        ok = 1'b0;
        k  = 0;
        c  = cyc;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && k < 50) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                c  = cyc;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("reset_values",
            64'({we, waddr, wdata, fetch_en, words_loaded, err}), 64'd0);
        chk("hdr_ready", 64'(in_ready), 64'd1);
    endtask

    // send header, data_q and (optionally) trailer, then check the outcome
    task automatic run_stream(input int n, input int gap, input bit bad);
        int          c;
        int          hc;
        int          lc;
        int          fc;
        int          exp_fc;
        logic [31:0] w;
        logic [7:0]  x;
        logic [7:0]  b;
`ifdef INST_LOADER_CHECKSUM_EN
        int          tc;
`endif
        w  = '0;
        x  = '0;
        lc = 0;
        fc = -1;
        send_byte(8'(n), pick(gap), hc);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = data_q[4*i+j];
                send_byte(b, pick(gap), c);
                w = {w[23:0], b};
                x = x ^ b;
                if (j == 3) begin
                    lc = c;
                    if (i < DEPTH) exp_q.push_back('{i, w, c + 1});
                end
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(bad ? (x ^ 8'h01) : x, pick(gap), tc);
        exp_fc = tc + 1;
`else
        exp_fc = (n == 0) ? hc + 1 : lc + 2;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fetch_en && fc < 0) fc = cyc;
        end
        if (bad)
            chk("fetch_held_low", 64'(fetch_en), 64'd0);
        else if (n <= DEPTH)
            chk("fetch_cycle", 64'(fc), 64'(exp_fc));
        else
            chk("fetch_en", 64'(fetch_en), 64'd1);
        chk("writes_missing", 64'(exp_q.size()), 64'd0);
        chk("words_loaded", 64'(words_loaded),
            64'((n > DEPTH) ? DEPTH : n));
        chk("err", 64'(err), 64'((n > DEPTH) || bad));
        chk("in_ready_done", 64'(in_ready), 64'd0);
    endtask

    task automatic fill_random(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
    endtask

    initial begin
        int n;
        int c;
        logic [31:0] w;
        repeat (2) @(posedge clk);
        do_reset();

        data_q = '{8'h34, 8'h01, 8'h00, 8'h0A, 8'h3C, 8'h02, 8'hFF, 8'hFF};
        run_stream(2, 0, 1'b0);
        do_reset();

        data_q.delete();
        run_stream(0, 0, 1'b0);
        do_reset();

        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_stream(1, 2, 1'b0);
        do_reset();

        fill_random(4 * 66);
        run_stream(66, 0, 1'b0);
        do_reset();

        // abort a 3-word load after 6 data bytes
        fill_random(6);
        w = '0;
        send_byte(8'd3, 0, c);
        for (int i = 0; i < 6; i++) begin
            send_byte(data_q[i], pick(-1), c);
            w = {w[23:0], data_q[i]};
            if (i == 3) exp_q.push_back('{0, w, c + 1});
        end
        do_reset();
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(1, 0, 1'b0);
        do_reset();

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 9));
            fill_random(4 * n);
            run_stream(n, -1, 1'b0);
            do_reset();
        end

`ifdef INST_LOADER_CHECKSUM_EN
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(1, 0, 1'b0);
        do_reset();
        run_stream(1, 0, 1'b1);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
